// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, fetch granule
// and the queue entry layout at the block's native 16-bit widths.
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES = 2;
    localparam int FQ_PC_W     = 16;
    localparam int FQ_INSTR_W  = 16;

    typedef struct packed {
        logic [FQ_INSTR_W-1:0] instr;
        logic [FQ_PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-request, decode-handshake and control bundle of fetch_queue.
// master = fetch unit, slave = memory/decode/control environment.
interface fetch_queue_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_ready;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;
    logic               halted;
    logic               err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, halted, err,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted, err,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count and a flush that wins over everything.
// Storage resets to zero so the head reads as zero out of reset.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == CW'(0));
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];
    // A full FIFO still takes a write when the head leaves in the same cycle
    assign do_wr_s = wr_en && (!full || rd_en);
    assign do_rd_s = rd_en && !empty;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= WIDTH'(0);
        end else if (do_wr_s && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: registered fetch PC, in-order response queue,
// redirect/halt with response discard. Optional FETCH_BYPASS_EN: zero-latency bypass.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int INSTR_W  = 16,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = INSTR_W + PC_W;

    fetch_state_e     state_r;
    logic             halted_r;
    logic             err_r;
    logic [PC_W-1:0]  pc_r;
    logic [PC_W-1:0]  resp_pc_r;
    logic [CW-1:0]    outstanding_r;
    logic [CW-1:0]    discard_r;
    logic [CW-1:0]    outstanding_next_s;
    logic [CW-1:0]    occupancy_s;
    logic [CW:0]      inflight_s;
    logic             req_s;
    logic             accept_s;
    logic             resp_s;
    logic             flush_s;
    logic             keep_s;
    logic             wr_s;
    logic             rd_s;
    logic             overflow_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [EW-1:0]    head_s;

    // Request gating: room for every request in flight, never during a redirect
    always_comb begin
        inflight_s = {1'b0, occupancy_s} + {1'b0, outstanding_r};
        if (state_r == RUN && !bus.redirect && inflight_s < (CW+1)'(DEPTH)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    assign accept_s = req_s && bus.imem_ready;
    assign resp_s   = bus.imem_rvalid && (outstanding_r != CW'(0));
    assign flush_s  = bus.redirect || (bus.halt && state_r == RUN);
    assign keep_s   = resp_s && (discard_r == CW'(0)) && !flush_s;

    // Outstanding count after this cycle's accept and response
    always_comb begin
        case ({accept_s, resp_s})
            2'b10:   outstanding_next_s = outstanding_r + CW'(1);
            2'b01:   outstanding_next_s = outstanding_r - CW'(1);
            default: outstanding_next_s = outstanding_r;
        endcase
    end

`ifdef FETCH_BYPASS_EN
    logic bypass_s;
    assign bypass_s        = keep_s && fifo_empty_s;
    assign wr_s            = keep_s && !(bypass_s && bus.instr_ready);
    assign rd_s            = !fifo_empty_s && bus.instr_ready;
    assign bus.instr_valid = !fifo_empty_s || bypass_s;
    assign bus.instr       = fifo_empty_s ? bus.imem_rdata : head_s[EW-1:PC_W];
    assign bus.instr_pc    = fifo_empty_s ? resp_pc_r : head_s[PC_W-1:0];
`else
    assign wr_s            = keep_s;
    assign rd_s            = !fifo_empty_s && bus.instr_ready;
    assign bus.instr_valid = !fifo_empty_s;
    assign bus.instr       = head_s[EW-1:PC_W];
    assign bus.instr_pc    = head_s[PC_W-1:0];
`endif

    assign overflow_s    = wr_s && fifo_full_s && !rd_s;
    assign bus.imem_req  = req_s;
    assign bus.imem_addr = pc_r;
    assign bus.halted    = halted_r;
    assign bus.err       = err_r;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_s),
        .wr_en   (wr_s),
        .wr_data ({bus.imem_rdata, resp_pc_r}),
        .rd_en   (rd_s),
        .rd_data (head_s),
        .count   (occupancy_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Fetch PC, and PC of the next response that will be kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= PC_W'(RESET_PC);
            resp_pc_r <= PC_W'(RESET_PC);
        end else if (bus.redirect) begin
            pc_r      <= bus.redirect_pc;
            resp_pc_r <= bus.redirect_pc;
        end else begin
            if (accept_s) pc_r <= pc_r + PC_W'(INSTR_BYTES);
            if (keep_s)   resp_pc_r <= resp_pc_r + PC_W'(INSTR_BYTES);
        end
    end

    // In-flight and discard counters; a flush discards everything still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_r <= CW'(0);
            discard_r     <= CW'(0);
        end else begin
            outstanding_r <= outstanding_next_s;
            if (flush_s) begin
                discard_r <= outstanding_next_s;
            end else if (resp_s && discard_r != CW'(0)) begin
                discard_r <= discard_r - CW'(1);
            end else begin
                discard_r <= discard_r;
            end
        end
    end

    // Fetch FSM; halt takes the state when it coincides with a redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= RUN;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    state_r  <= bus.halt ? DRAIN : RUN;
                    halted_r <= 1'b0;
                end
                DRAIN: begin
                    if (bus.redirect && bus.halt) begin
                        state_r  <= DRAIN;
                        halted_r <= 1'b0;
                    end else if (bus.redirect) begin
                        state_r  <= RUN;
                        halted_r <= 1'b0;
                    end else if (outstanding_next_s == CW'(0)) begin
                        state_r  <= HALTED;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= DRAIN;
                        halted_r <= 1'b0;
                    end
                end
                HALTED: begin
                    if (bus.redirect) begin
                        state_r  <= bus.halt ? DRAIN : RUN;
                        halted_r <= 1'b0;
                    end else begin
                        state_r  <= HALTED;
                        halted_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error: orphan response, misaligned redirect, queue overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((bus.imem_rvalid && outstanding_r == CW'(0)) ||
                     (bus.redirect && bus.redirect_pc[0]) || overflow_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: an in-order memory model feeds responses,
// expected {instr, pc} entries are queued on each accepted request.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mem_req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_queue #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    mem_req_t     pend[$];
    fetch_entry_t exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           mem_lat = 1;
    logic         mem_ready = 1'b1;
    logic [15:0]  model_pc = 16'h0000;
    int           n_acc = 0;
    int           n_deq = 0;
    int           first_valid = -1;
    int           last_resp_cyc = -1;
    logic [15:0]  first_deq_pc = 16'h0000;
    int           s_cyc = 0;
    logic         s_req, s_valid, s_halted, s_err;
    logic [15:0]  s_addr, s_instr, s_pc;

    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock cycle: drive at the negedge, sample 1ns later, advance to next negedge
    task automatic step(input logic rdy, input logic redir, input logic [15:0] rpc,
                        input logic hlt, input logic spurious);
        mem_req_t     m;
        fetch_entry_t e;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.halt        = hlt;
        bus.imem_ready  = mem_ready;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0000;
        if (spurious) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 16'hDEAD;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            m = pend.pop_front();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_data(m.addr);
            last_resp_cyc   = cyc;
        end
        #1;
        s_cyc    = cyc;
        s_req    = bus.imem_req;
        s_addr   = bus.imem_addr;
        s_valid  = bus.instr_valid;
        s_instr  = bus.instr;
        s_pc     = bus.instr_pc;
        s_halted = bus.halted;
        s_err    = bus.err;
        if (bus.instr_valid && first_valid < 0) first_valid = cyc;
        if (redir) check("req_during_redirect", bus.imem_req, 1'b0);
        if (bus.imem_req && mem_ready) begin
            check("imem_addr", bus.imem_addr, model_pc);
            pend.push_back('{addr: model_pc, due: cyc + mem_lat});
            exp_q.push_back('{instr: mem_data(model_pc), pc: model_pc});
            model_pc = model_pc + 16'h0002;
            n_acc++;
        end
        if (bus.instr_valid && rdy) begin
            n_deq++;
            if (exp_q.size() == 0) begin
                check("spurious_instr_valid", bus.instr_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                if (n_deq == 1) first_deq_pc = e.pc;
                check("instr", bus.instr, e.instr);
                check("instr_pc", bus.instr_pc, e.pc);
            end
        end
        if (redir) model_pc = rpc;
        if (redir || hlt) exp_q.delete();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.halt        = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0000;
        pend.delete();
        exp_q.delete();
        model_pc  = 16'h0000;
        mem_ready = 1'b1;
        mem_lat   = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_imem_req", bus.imem_req, 1'b1);
        check("rst_imem_addr", bus.imem_addr, 16'h0000);
        check("rst_instr_valid", bus.instr_valid, 1'b0);
        check("rst_instr", bus.instr, 16'h0000);
        check("rst_instr_pc", bus.instr_pc, 16'h0000);
        check("rst_halted", bus.halted, 1'b0);
        check("rst_err", bus.err, 1'b0);
        rst           = 1'b0;
        cyc           = 0;
        n_acc         = 0;
        n_deq         = 0;
        first_valid   = -1;
        last_resp_cyc = -1;
    endtask

    initial begin
        int halted_cyc;

        // Streaming with 1-cycle memory and decode always ready
        do_reset();
        repeat (22) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef FETCH_BYPASS_EN
        check("t1_first_valid", first_valid, 1);
        check("t1_deq_count", n_deq, 21);
`else
        check("t1_first_valid", first_valid, 2);
        check("t1_deq_count", n_deq, 20);
`endif
        check("t1_err", s_err, 1'b0);

        // Latency 3, decode stalled: outstanding limit then queue full; reset hits mid-flight
        do_reset();
        mem_lat = 3;
        repeat (10) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t2_req_count", n_acc, 4);
        check("t2_req_held_low", s_req, 1'b0);
        check("t2_head_valid", s_valid, 1'b1);
        check("t2_head_instr", s_instr, mem_data(16'h0000));
        check("t2_head_pc", s_pc, 16'h0000);
        repeat (12) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t2_first4_drained", n_deq >= 4, 1'b1);
        check("t2_fetch_resumed", n_acc > 4, 1'b1);

        // Redirect with three requests outstanding
        do_reset();
        mem_lat = 3;
        repeat (3) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
        n_deq = 0;
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t3_req_after_redirect", s_req, 1'b1);
        check("t3_addr_after_redirect", s_addr, 16'h0100);
        repeat (10) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t3_first_pc", first_deq_pc, 16'h0100);
        check("t3_deq_seen", n_deq > 0, 1'b1);

        // Halt with two requests outstanding, then restart by redirect
        do_reset();
        mem_lat = 4;
        repeat (2) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        mem_ready = 1'b0;
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        halted_cyc = -1;
        for (int i = 0; i < 20 && halted_cyc < 0; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
            check("t4_no_req_while_halting", s_req, 1'b0);
            if (s_halted) halted_cyc = s_cyc;
        end
        check("t4_halt_latency", halted_cyc, last_resp_cyc + 1);
        mem_ready = 1'b1;
        step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t4_restart_req", s_req, 1'b1);
        check("t4_restart_addr", s_addr, 16'h0040);
        check("t4_halted_cleared", s_halted, 1'b0);
        repeat (6) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t4_err", s_err, 1'b0);

        // PC wraps modulo 2^16
        do_reset();
        mem_lat = 2;
        step(1'b1, 1'b1, 16'hFFFC, 1'b0, 1'b0);
        n_deq = 0;
        repeat (10) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t5_wrap_first_pc", first_deq_pc, 16'hFFFC);
        check("t5_wrap_err", s_err, 1'b0);

        // Orphan response while halted sets a sticky error
        do_reset();
        mem_ready = 1'b0;
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t6_halted", s_halted, 1'b1);
        check("t6_err_before", s_err, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t6_err_set", s_err, 1'b1);
        repeat (3) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t6_err_sticky", s_err, 1'b1);

        // Misaligned redirect target
        do_reset();
        step(1'b1, 1'b1, 16'h0003, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t7_err_odd_redirect", s_err, 1'b1);

        // Same-cycle visibility of a response into an empty queue
        do_reset();
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef FETCH_BYPASS_EN
        check("t8_bypass_valid", s_valid, 1'b1);
        check("t8_bypass_instr", s_instr, mem_data(16'h0000));
`else
        check("t8_no_bypass_valid", s_valid, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("t8_next_cycle_instr", s_instr, mem_data(16'h0000));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined successor of the single-cycle processor. Issues word requests to instruction memory with a registered PC, buffers in-order responses in a DEPTH-entry queue, and presents instructions to decode over a valid/ready handshake. Handles redirects (branch/jump) and halt without ever losing or duplicating an instruction.

## Interface
- PC_W, 16, PC/address width
- INSTR_W, 16, instruction width
- DEPTH, 4, queue entries; power of two, ≥2; also the outstanding-request limit
- RESET_PC, 0, PC loaded at reset; must be even

- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- imem_req  out  1  request valid
- imem_addr  out  PC_W  request address (current fetch PC)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses in request order, latency ≥1
- imem_rdata  in  INSTR_W  response data
- instr_valid  out  1  queue head valid
- instr  out  INSTR_W  head instruction
- instr_pc  out  PC_W  address of head instruction
- instr_ready  in  1  decode accepts head
- redirect  in  1  flush and restart at redirect_pc
- redirect_pc  in  PC_W  new fetch PC
- halt  in  1  stop fetching
- halted  out  1  fetch fully idle after halt
- err  out  1  sticky error

## Operation
- States: RUN, DRAIN, HALTED.
- RUN: imem_req=1 when occupancy+outstanding < DEPTH and redirect=0. On accept (req&ready): outstanding+1, fetch PC += 2, modulo 2^PC_W.
- Response: if discard counter >0, drop it and decrement. Otherwise write {rdata, pc} to the queue. In both cases outstanding-1.
- Dequeue on instr_valid&instr_ready.
- redirect (any state):
  - flush queue; fetch PC ← redirect_pc.
  - discard ← outstanding after this cycle's accept/response updates.
  - imem_req forced 0 that cycle.
  - A same-cycle dequeue completes (decode owns that instruction).
  - A same-cycle response is dropped.
  - From HALTED or DRAIN, next state is RUN.
- halt in RUN: flush queue; discard ← all outstanding; go to DRAIN. imem_req=0 in DRAIN and HALTED.
- DRAIN → HALTED when outstanding==0. halted=1 only in HALTED.
- halt and redirect in the same cycle: PC ← redirect_pc, state DRAIN (halt wins the state).
- err set, cleared only by reset, on:
  - imem_rvalid with outstanding==0;
  - redirect with redirect_pc[0]=1;
  - queue overflow (must be unreachable).
- Counter widths: occupancy and outstanding use $clog2(DEPTH+1) bits; pointers use $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values: state RUN, PC=RESET_PC, queue empty, outstanding=0, discard=0, imem_req=1 (combinational from reset state), imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, err=0.
- imem_req/imem_addr are combinational from registered state and redirect. No dependency on imem_ready.
- Response in cycle N → instr_valid in N+1 (no bypass).
- Redirect in cycle N → first request to redirect_pc in N+1.
- Full throughput: 1 instr/cycle when memory latency ≤ DEPTH-1 and decode is always ready.
- Queue full with instr_ready=0: no requests; a held head stays stable.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight memory responses after reset release are an environment error.

## Configuration
- FETCH_BYPASS_EN defined: a non-discarded response arriving with the queue empty appears on instr/instr_valid in the same cycle. If instr_ready=1 it is consumed without a write; otherwise it is written. Latency 0.
- Undefined: all responses pass through the queue; latency 1, with no combinational path from imem_rdata to instr.

## Structure
- Package fetch_pkg: state enum (RUN, DRAIN, HALTED), INSTR_BYTES=2 constant, and the queue entry struct {instr, pc}.
- One sub-module, fetch_fifo: parametrised synchronous FIFO with count, flush, full and empty.
- FSM, counters and PC live in fetch_queue.

## Test plan
- Reset, 1-cycle memory, ready always high → addresses 0,2,4,6…; instr_valid from cycle 2 then continuous; instr_pc matches each instruction.
- Memory latency 3, instr_ready=0 → exactly 4 requests issued, imem_req then held 0. Release ready → 4 instructions in order, then fetch resumes.
- Redirect to 0x0100 with 3 requests outstanding → 3 responses dropped; next instr_pc=0x0100; no stale instruction seen.
- halt with 2 requests outstanding → halted=1 one cycle after the second response. Then redirect to 0x0040 → RUN; first request addr 0x0040.
- Spurious imem_rvalid in HALTED → err=1 and stays 1 until rst. A separate redirect_pc=0x0003 also sets err.
- With FETCH_BYPASS_EN, empty queue, instr_ready=1 → response data appears on instr in the same cycle as imem_rvalid.
